// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM state
// encoding and a parity helper.
package alu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_INC   = 4'd4;
  localparam logic [3:0] OP_DEC   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_ROL   = 4'd8;
  localparam logic [3:0] OP_ROR   = 4'd9;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_XOR   = 4'd11;
  localparam logic [3:0] OP_SHL   = 4'd12;
  localparam logic [3:0] OP_SHR   = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_INV15 = 4'd15;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  localparam int PARITY_MAX_W = 64;

  // Zero-extension does not change parity, so one wide helper serves any width.
  function automatic logic odd_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per clock.
// done/product are presented combinationally during the final step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUS_WIDTH-1:0]   a,
  input  logic [BUS_WIDTH-1:0]   b,
  output logic                   done,
  output logic [2*BUS_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(BUS_WIDTH);

  logic [2*BUS_WIDTH-1:0] mcand_reg;
  logic [2*BUS_WIDTH-1:0] prod_reg;
  logic [2*BUS_WIDTH-1:0] prod_next;
  logic [BUS_WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]       count_reg;
  logic                   run_reg;

  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done      = run_reg && (count_reg == CNT_W'(BUS_WIDTH - 1));
  assign product   = prod_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start && !run_reg) begin
      mcand_reg  <= {{BUS_WIDTH{1'b0}}, a};
      prod_reg   <= '0;
      mplier_reg <= b;
      count_reg  <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CNT_W'(1);
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on operands and results;
// single-cycle ops finish on the accept edge, MUL runs iteratively.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int BUS_WIDTH = 8,
  localparam int SHAMT_W   = $clog2(BUS_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [BUS_WIDTH-1:0] y_hi,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op,
  output logic                 busy
);

  state_t                 state_reg;
  logic                   out_valid_reg;
  logic [BUS_WIDTH-1:0]   y_reg;
  logic [BUS_WIDTH-1:0]   y_hi_reg;
  logic                   carry_reg;
  logic                   borrow_reg;
  logic                   zero_reg;
  logic                   parity_reg;
  logic                   invalid_reg;
  logic                   busy_reg;

  logic                   accept;
  logic                   consume;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*BUS_WIDTH-1:0] mul_product;

  logic [SHAMT_W-1:0]     shamt;
  logic [2*BUS_WIDTH-1:0] rol_wide;
  logic [2*BUS_WIDTH-1:0] ror_wide;
  logic [BUS_WIDTH:0]     shl_wide;

  logic [BUS_WIDTH-1:0]   res_y;
  logic                   res_c;
  logic                   res_b;
  logic                   res_inv;

  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_reg && out_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  assign out_valid  = out_valid_reg;
  assign y          = y_reg;
  assign y_hi       = y_hi_reg;
  assign carry_out  = carry_reg;
  assign borrow     = borrow_reg;
  assign zero       = zero_reg;
  assign parity     = parity_reg;
  assign invalid_op = invalid_reg;
  assign busy       = busy_reg;

  // Rotates fall out of shifting a doubled copy of the operand.
  assign shamt    = b[SHAMT_W-1:0];
  assign rol_wide = {a, a} << shamt;
  assign ror_wide = {a, a} >> shamt;
  assign shl_wide = {1'b0, a} << shamt;

  always_comb begin
    res_y   = '0;
    res_c   = 1'b0;
    res_b   = 1'b0;
    res_inv = 1'b0;
    case (opcode)
      OP_ADD: {res_c, res_y} = {1'b0, a} + {1'b0, b};
      OP_ADC: {res_c, res_y} = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
      OP_SUB: begin
        res_y = a - b;
        res_b = (a < b);
      end
      OP_INC: {res_c, res_y} = {1'b0, a} + (BUS_WIDTH+1)'(1);
      OP_DEC: begin
        res_y = a - BUS_WIDTH'(1);
        res_b = (a == '0);
      end
      OP_AND: res_y = a & b;
      OP_NOT: res_y = ~a;
      OP_OR:  res_y = a | b;
      OP_XOR: res_y = a ^ b;
      OP_ROL: res_y = rol_wide[2*BUS_WIDTH-1:BUS_WIDTH];
      OP_ROR: res_y = ror_wide[BUS_WIDTH-1:0];
      OP_SHL: begin
        res_y = shl_wide[BUS_WIDTH-1:0];
        res_c = shl_wide[BUS_WIDTH];
      end
      OP_SHR: res_y = a >> shamt;
      OP_MUL: res_y = '0;
      OP_NOP, OP_INV15: res_inv = 1'b1;
      default: res_inv = 1'b1;
    endcase
  end

  alu_mul_seq #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      y_hi_reg      <= '0;
      carry_reg     <= 1'b0;
      borrow_reg    <= 1'b0;
      zero_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      invalid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      if (mul_start) begin
        // Any previous result is consumed on this edge; nothing shows until done.
        state_reg     <= ST_MUL_BUSY;
        busy_reg      <= 1'b1;
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        y_reg         <= res_y;
        y_hi_reg      <= '0;
        carry_reg     <= res_c;
        borrow_reg    <= res_b;
        zero_reg      <= !res_inv && (res_y == '0);
        parity_reg    <= odd_parity(PARITY_MAX_W'(res_y));
        invalid_reg   <= res_inv;
      end else if (consume) begin
        out_valid_reg <= 1'b0;
      end
    end else if (mul_done) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b1;
      y_reg         <= mul_product[BUS_WIDTH-1:0];
      y_hi_reg      <= mul_product[2*BUS_WIDTH-1:BUS_WIDTH];
      carry_reg     <= (mul_product[2*BUS_WIDTH-1:BUS_WIDTH] != '0);
      borrow_reg    <= 1'b0;
      zero_reg      <= (mul_product == '0);
      parity_reg    <= odd_parity(PARITY_MAX_W'(mul_product[BUS_WIDTH-1:0]));
      invalid_reg   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic
// reference model of each opcode.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         carry_out;
  logic         borrow;
  logic         zero;
  logic         parity;
  logic         invalid_op;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int unsigned y;
    int unsigned yhi;
    bit          c;
    bit          bo;
    bit          z;
    bit          p;
    bit          inv;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_hi       (y_hi),
    .carry_out  (carry_out),
    .borrow     (borrow),
    .zero       (zero),
    .parity     (parity),
    .invalid_op (invalid_op),
    .busy       (busy)
  );

  function automatic exp_t model(input int unsigned op, input int unsigned x,
                                 input int unsigned z, input bit ci);
    exp_t        e;
    int unsigned mask;
    int unsigned s;
    int unsigned r;
    longint unsigned p;
    mask  = (1 << W) - 1;
    s     = z % W;
    r     = 0;
    e.y   = 0;
    e.yhi = 0;
    e.c   = 0;
    e.bo  = 0;
    e.z   = 0;
    e.p   = 0;
    e.inv = 0;
    case (op)
      1:  begin r = x + z;      e.c  = (r > mask); end
      2:  begin r = x + z + ci; e.c  = (r > mask); end
      3:  begin r = x - z;      e.bo = (x < z);    end
      4:  begin r = x + 1;      e.c  = (r > mask); end
      5:  begin r = x - 1;      e.bo = (x == 0);   end
      6:  r = x & z;
      7:  r = ~x;
      10: r = x | z;
      11: r = x ^ z;
      8:  r = (x << s) | (x >> (W - s));
      9:  r = (x >> s) | (x << (W - s));
      12: begin r = x << s; e.c = ((r >> W) & 1) == 1; end
      13: r = x >> s;
      14: begin
        p     = longint'(x) * longint'(z);
        r     = 32'(p);
        e.yhi = 32'(p >> W);
        e.c   = (e.yhi != 0);
      end
      default: e.inv = 1;
    endcase
    e.y = r & mask;
    e.z = !e.inv && (e.y == 0) && (e.yhi == 0);
    e.p = ($countones(e.y) % 2) == 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for its result and compare every output.
  task automatic run_op(input int op, input int unsigned xa, input int unsigned xb, input bit ci);
    exp_t e;
    int   lat;
    int   busy_cycles;
    e   = model(op, xa, xb, ci);
    lat = 0;
    while (!in_ready && lat < 50) begin
      step();
      lat++;
    end
    chk($sformatf("op%0d in_ready", op), 32'(in_ready), 32'd1);
    opcode   = 4'(op);
    a        = W'(xa);
    b        = W'(xb);
    carry_in = ci;
    in_valid = 1'b1;
    step();
    in_valid    = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!out_valid && lat < 40) begin
      if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
      step();
      lat++;
    end
    chk($sformatf("op%0d latency", op), 32'(lat), (op == 14) ? 32'(W) : 32'd0);
    if (op == 14) chk("mul busy_cycles", 32'(busy_cycles), 32'(W));
    $display("op=%0d a=%0h b=%0h ci=%0d -> y=%0h y_hi=%0h c=%0d bo=%0d z=%0d p=%0d inv=%0d",
             op, xa, xb, ci, y, y_hi, carry_out, borrow, zero, parity, invalid_op);
    chk($sformatf("op%0d y", op),       32'(y),          e.y);
    chk($sformatf("op%0d y_hi", op),    32'(y_hi),       e.yhi);
    chk($sformatf("op%0d carry", op),   32'(carry_out),  32'(e.c));
    chk($sformatf("op%0d borrow", op),  32'(borrow),     32'(e.bo));
    chk($sformatf("op%0d zero", op),    32'(zero),       32'(e.z));
    chk($sformatf("op%0d parity", op),  32'(parity),     32'(e.p));
    chk($sformatf("op%0d invalid", op), 32'(invalid_op), 32'(e.inv));
    chk($sformatf("op%0d busy", op),    32'(busy),       32'd0);
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " y"},         32'(y),         32'd0);
    chk({tag, " y_hi"},      32'(y_hi),      32'd0);
    chk({tag, " flags"},     32'({carry_out, borrow, zero, parity, invalid_op}), 32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_all_clear("reset");
    #2 rst_n = 1'b1;
    step();
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Arithmetic
    run_op(1, 9, 33, 0);
    run_op(2, 9, 33, 1);
    run_op(3, 65, 66, 0);
    run_op(3, 65, 64, 0);
    run_op(4, 255, 0, 0);
    run_op(5, 0, 0, 0);

    // Multiply
    run_op(14, 200, 3, 0);
    run_op(14, 0, 77, 0);
    run_op(14, 255, 255, 0);

    // Shifts and rotates, including an amount taken from the low bits only
    run_op(8, 8'h81, 1, 0);
    run_op(9, 8'h01, 3, 0);
    run_op(12, 8'h81, 1, 0);
    run_op(13, 8'h80, 7, 0);
    run_op(12, 8'h81, 9, 0);
    run_op(12, 8'h81, 0, 0);

    // Back-pressure: result held while a new operand waits
    step();
    out_ready = 1'b0;
    run_op(1, 5, 6, 0);
    opcode   = 4'd11;
    a        = 8'h3C;
    b        = 8'h0F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold y", 32'(y), 32'd11);
      chk("hold flags", 32'({carry_out, borrow, zero, parity}), 32'b0001);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    $display("backpressure release -> y=%0h out_valid=%0d", y, out_valid);
    chk("release y", 32'(y), 32'h33);
    chk("release out_valid", 32'(out_valid), 32'd1);
    step();
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Reset part-way through a multiply
    opcode   = 4'd14;
    a        = 8'd200;
    b        = 8'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_clear("midmul reset");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post reset out_valid", 32'(out_valid), 32'd0);
      chk("post reset busy", 32'(busy), 32'd0);
    end
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    run_op(15, 8'hA5, 8'h5A, 1);
    run_op(0, 8'hFF, 8'h01, 0);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      run_op(int'($urandom_range(0, 15)), $urandom_range(0, 255),
             $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
